dot_product_seq_ctrl: RTL and testbench
=======================================

DOT_PRODUCT_SEQ_CTRL -- requirements
Module: dot_product_seq_ctrl

Interface
REQ-001 The block SHALL have parameter LEN_W, default 8, width of the chunk-count field (1 chunk = 8 byte lanes).
REQ-002 The block SHALL have parameter ACC_W, default 19+LEN_W, accumulator and result width.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 cmd_valid  input  1  job request valid.
REQ-007 cmd_ready  output  1  job request accepted when high with cmd_valid.
REQ-008 cmd_len  input  LEN_W  number of 64-bit chunk pairs in job, 0..2^LEN_W-1.
REQ-009 chunk_valid  input  1  vec_a/vec_b valid.
REQ-010 chunk_ready  output  1  chunk accepted when high with chunk_valid.
REQ-011 vec_a, vec_b  input  64 each  8 unsigned byte lanes, lane i at [i*8 +: 8].
REQ-012 res_valid  output  1  result available.
REQ-013 res_ready  input  1  result consumed when high with res_valid.
REQ-014 res_data  output  ACC_W  unsigned sum over all chunks of the 8-lane dot product.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The block SHALL instantiate one internal 8-lane dot-product datapath (8 parallel 8x8 unsigned multiplies, tree-add to 19 bits) and SHALL register its output in one pipeline register (prod_q plus valid bit).
REQ-017 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE: cmd_ready=1; on cmd handshake, clear accumulator, load remaining=cmd_len; go to RUN if cmd_len>0, else DONE.
REQ-019 RUN: chunk_ready=1; each chunk handshake captures the datapath output into prod_q and decrements remaining; on the handshake with remaining==1, go to DRAIN.
REQ-020 Whenever prod_q is valid, the accumulator SHALL add prod_q (zero-extended) on the next edge; there is no bubble penalty for back-to-back chunks.
REQ-021 DRAIN: lasts exactly one cycle; the final prod_q is accumulated; then go to DONE.
REQ-022 DONE: res_valid=1, res_data=accumulator; on res_ready, go to IDLE.
REQ-023 res_data and res_valid SHALL remain stable while res_valid=1 and res_ready=0.
REQ-024 res_valid SHALL rise exactly 2 clock edges after the last chunk handshake, and 1 edge after the cmd handshake when cmd_len=0.
REQ-025 cmd_ready SHALL be 0 outside IDLE; the next command is accepted no earlier than the cycle after the result handshake.
REQ-026 chunk_valid outside RUN SHALL be ignored (chunk_ready=0, no state change).
REQ-027 Arithmetic SHALL be unsigned; ACC_W=19+LEN_W guarantees no overflow (max 255*8*65025=132651000 < 2^27 at defaults); no saturation or wrap logic.
REQ-028 res_data SHALL read 0 in every state other than DONE.

Reset
REQ-029 On rst assertion, the block SHALL immediately (asynchronously) enter IDLE and clear accumulator, remaining, prod_q and its valid bit.
REQ-030 While rst is asserted, outputs SHALL be: cmd_ready=0, chunk_ready=0, res_valid=0, res_data=0, busy=0. cmd_ready SHALL become 1 on the first edge after deassertion.
REQ-031 A job interrupted by reset SHALL be discarded, with no partial result and no residue in the next job.

Verification
REQ-032 len=1, vec_a lanes=0x01, vec_b lanes=0x02 -> res_data=16; res_valid rises exactly 2 edges after the chunk handshake.
REQ-033 len=255, all lanes 0xFF, chunk_valid held high -> 255 consecutive handshakes; res_data=132651000; no overflow.
REQ-034 len=0 -> chunk_ready never high; res_valid 1 edge after the cmd handshake; res_data=0.
REQ-035 len=3, vec_a lane i = i+1, vec_b lanes=1, chunk_valid gapped 1-3 cycles, res_ready low 5 cycles -> res_data=108 and stable; cmd_ready=0 until the handshake, then 1.
REQ-036 len=4, rst pulsed after 2 chunk handshakes -> outputs reset immediately; a new job len=1 with lanes a=0x03, b=0x03 -> res_data=72.
REQ-037 A cmd_valid pulse during RUN, and chunk_valid during IDLE or DONE, SHALL be ignored; the in-flight result is unchanged.

Source files
------------

// File: rtl/dot_product_seq_ctrl_if.sv
// Handshake bundle for the sequential dot-product controller: command, chunk stream,
// result and status signals.
interface dot_product_seq_ctrl_if #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned ACC_W = 19 + LEN_W
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             chunk_valid;
    logic             chunk_ready;
    logic [63:0]      vec_a;
    logic [63:0]      vec_b;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic             busy;

    // Job producer / result consumer side.
    modport master (
        output cmd_valid, cmd_len, chunk_valid, vec_a, vec_b, res_ready,
        input  cmd_ready, chunk_ready, res_valid, res_data, busy
    );

    // Controller side.
    modport slave (
        input  cmd_valid, cmd_len, chunk_valid, vec_a, vec_b, res_ready,
        output cmd_ready, chunk_ready, res_valid, res_data, busy
    );
endinterface

// File: rtl/dot_product_seq_ctrl.sv
// Sequential dot-product controller: accepts a job of cmd_len 64-bit chunk pairs,
// multiplies 8 unsigned byte lanes per chunk, and accumulates into one result.
module dot_product_seq_ctrl #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned ACC_W = 19 + LEN_W
) (
    input logic                   clk,
    input logic                   rst,
    dot_product_seq_ctrl_if.slave bus
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [18:0]      prod_q, prod_d;
    logic             prod_vld_q, prod_vld_d;
    // Holds cmd_ready low during reset and until the first edge after release.
    logic             rdy_en_q;

    logic [15:0] lane_prod [8];
    logic [16:0] sum_l1 [4];
    logic [17:0] sum_l2 [2];
    logic [18:0] dp_sum;

    logic cmd_hs;
    logic chunk_hs;

    // 8-lane unsigned multiply followed by a three-level adder tree.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lane_prod[i] = {8'd0, bus.vec_a[i*8 +: 8]} * {8'd0, bus.vec_b[i*8 +: 8]};
        end
        for (int i = 0; i < 4; i++) begin
            sum_l1[i] = {1'b0, lane_prod[2*i]} + {1'b0, lane_prod[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            sum_l2[i] = {1'b0, sum_l1[2*i]} + {1'b0, sum_l1[2*i+1]};
        end
        dp_sum = {1'b0, sum_l2[0]} + {1'b0, sum_l2[1]};
    end

    assign cmd_hs   = (state_q == StIdle) && rdy_en_q && bus.cmd_valid;
    assign chunk_hs = (state_q == StRun) && bus.chunk_valid;

    // Next-state: FSM sequencing, chunk capture and accumulation.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        prod_d     = prod_q;
        prod_vld_d = 1'b0;
        acc_d      = acc_q;

        // Pipelined product lands in the accumulator one edge after capture.
        if (prod_vld_q) begin
            acc_d = acc_q + ACC_W'(prod_q);
        end

        unique case (state_q)
            StIdle: begin
                if (cmd_hs) begin
                    acc_d   = '0;
                    rem_d   = bus.cmd_len;
                    state_d = (bus.cmd_len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (chunk_hs) begin
                    prod_d     = dp_sum;
                    prod_vld_d = 1'b1;
                    rem_d      = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                state_d = StDone;
            end
            StDone: begin
                if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset discards any in-flight job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rem_q      <= '0;
            acc_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            rdy_en_q   <= 1'b1;
        end
    end

    // Outputs decoded from state; result is zero outside DONE.
    always_comb begin
        bus.cmd_ready   = (state_q == StIdle) && rdy_en_q;
        bus.chunk_ready = (state_q == StRun);
        bus.res_valid   = (state_q == StDone);
        bus.res_data    = (state_q == StDone) ? acc_q : '0;
        bus.busy        = (state_q != StIdle);
    end

endmodule

// File: tb/tb_dot_product_seq_ctrl.sv
// Directed bench for dot_product_seq_ctrl with hand-computed expected results.
module tb_dot_product_seq_ctrl;
    localparam int unsigned LEN_W = 8;
    localparam int unsigned ACC_W = 27;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    dot_product_seq_ctrl_if #(.LEN_W(LEN_W), .ACC_W(ACC_W)) bus ();

    dot_product_seq_ctrl #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rst_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
        check({tag, "_chunk_ready"}, 64'(bus.chunk_ready), 64'd0);
        check({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
        check({tag, "_res_data"}, 64'(bus.res_data), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    // Runs one job of len identical chunks; gapped inserts 1-3 idle cycles before each
    // chunk and pokes cmd_valid in RUN; hold keeps res_ready low while pestering DONE.
    task automatic run_job(input string tag, input int len, input logic [63:0] a,
                           input logic [63:0] b, input bit gapped, input int hold,
                           input logic [63:0] exp);
        int n;
        int stalls;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LEN_W'(len);
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
        tick();
        bus.cmd_valid = 1'b0;
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        check({tag, "_cmd_ready_busy"}, 64'(bus.cmd_ready), 64'd0);
        if (len == 0) begin
            check({tag, "_chunk_ready_len0"}, 64'(bus.chunk_ready), 64'd0);
            check({tag, "_res_valid_lat"}, 64'(bus.res_valid), 64'd1);
        end else begin
            stalls = 0;
            for (int k = 0; k < len; k++) begin
                if (gapped) begin
                    for (int g = 0; g <= (k % 3); g++) begin
                        bus.chunk_valid = 1'b0;
                        if (k == 1 && g == 0) begin
                            bus.cmd_valid = 1'b1;
                            check({tag, "_cmd_in_run"}, 64'(bus.cmd_ready), 64'd0);
                        end
                        check({tag, "_gap_ready"}, 64'(bus.chunk_ready), 64'd1);
                        tick();
                        bus.cmd_valid = 1'b0;
                    end
                end
                bus.chunk_valid = 1'b1;
                bus.vec_a       = a;
                bus.vec_b       = b;
                n = 0;
                while (!bus.chunk_ready && n < 50) begin
                    tick();
                    n++;
                    stalls++;
                end
                if (n >= 50) begin
                    check({tag, "_chunk_timeout"}, 64'(bus.chunk_ready), 64'd1);
                end
                tick();
            end
            bus.chunk_valid = 1'b0;
            if (!gapped) begin
                check({tag, "_stalls"}, 64'(stalls), 64'd0);
            end
            check({tag, "_res_valid_edge1"}, 64'(bus.res_valid), 64'd0);
            check({tag, "_chunk_ready_drain"}, 64'(bus.chunk_ready), 64'd0);
            tick();
            check({tag, "_res_valid_edge2"}, 64'(bus.res_valid), 64'd1);
        end
        check({tag, "_res_data"}, 64'(bus.res_data), exp);
        for (int h = 0; h < hold; h++) begin
            bus.cmd_valid   = 1'b1;
            bus.chunk_valid = 1'b1;
            bus.vec_a       = '1;
            bus.vec_b       = '1;
            check({tag, "_hold_cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
            check({tag, "_hold_chunk_ready"}, 64'(bus.chunk_ready), 64'd0);
            tick();
            check({tag, "_hold_valid"}, 64'(bus.res_valid), 64'd1);
            check({tag, "_hold_data"}, 64'(bus.res_data), exp);
        end
        bus.cmd_valid   = 1'b0;
        bus.chunk_valid = 1'b0;
        bus.res_ready   = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check({tag, "_post_valid"}, 64'(bus.res_valid), 64'd0);
        check({tag, "_post_data"}, 64'(bus.res_data), 64'd0);
        check({tag, "_post_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
        check({tag, "_post_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_len     = '0;
        bus.chunk_valid = 1'b0;
        bus.vec_a       = '0;
        bus.vec_b       = '0;
        bus.res_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_rst_outputs("reset");
        rst = 1'b0;
        check("rdy_before_edge", 64'(bus.cmd_ready), 64'd0);
        tick();
        check("rdy_after_edge", 64'(bus.cmd_ready), 64'd1);

        // 8 lanes of 1*2.
        run_job("len1", 1, {8{8'h01}}, {8{8'h02}}, 1'b0, 0, 64'd16);
        // 255 full chunks of 8*255*255, back to back.
        run_job("len255", 255, {8{8'hFF}}, {8{8'hFF}}, 1'b0, 0, 64'd132651000);

        // Chunks offered in IDLE must be ignored.
        bus.chunk_valid = 1'b1;
        bus.vec_a       = '1;
        bus.vec_b       = '1;
        repeat (2) begin
            tick();
            check("idle_chunk_ready", 64'(bus.chunk_ready), 64'd0);
            check("idle_busy", 64'(bus.busy), 64'd0);
        end
        bus.chunk_valid = 1'b0;

        run_job("len0", 0, '0, '0, 1'b0, 2, 64'd0);
        // Lanes 1..8 times 1 = 36 per chunk, 3 chunks.
        run_job("len3", 3, 64'h0807060504030201, {8{8'h01}}, 1'b1, 5, 64'd108);

        // Abort a len=4 job after two chunks.
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'd4;
        tick();
        bus.cmd_valid   = 1'b0;
        bus.chunk_valid = 1'b1;
        bus.vec_a       = '1;
        bus.vec_b       = '1;
        tick();
        tick();
        bus.chunk_valid = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_rst_outputs("abort");
        tick();
        tick();
        rst = 1'b0;
        check("abort_rdy_before", 64'(bus.cmd_ready), 64'd0);
        tick();
        check("abort_rdy_after", 64'(bus.cmd_ready), 64'd1);
        // 8 lanes of 3*3 with no residue from the aborted job.
        run_job("after_rst", 1, {8{8'h03}}, {8{8'h03}}, 1'b0, 0, 64'd72);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
